// File: rtl/multi_pio_bank_pkg.sv
// multi_pio_pkg: shared constants for the multi-channel PIO bank.
//   - reg_sel_e    : per-channel word offsets (low two address bits)
//   - EDGE_*       : capture-edge encodings for the EDGE_MODE parameter
//   - addr_width() : Avalon word-address width for a given channel count
package multi_pio_pkg;

    typedef enum logic [1:0] {
        REG_DATA_IN  = 2'd0,
        REG_DATA_OUT = 2'd1,
        REG_IRQ_MASK = 2'd2,
        REG_EDGE_CAP = 2'd3
    } reg_sel_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Channel index bits sit above the two register-offset bits.
    function automatic int addr_width(input int num_ch);
        return $clog2(num_ch) + 2;
    endfunction

endpackage

// File: rtl/multi_pio_bank_if.sv
// multi_pio_bank_if: Avalon-MM slave bus of the PIO bank.
//   avs_address       {channel, register} word address (ADDR_W bits)
//   avs_read/write    access strobes
//   avs_writedata     32-bit write data
//   avs_readdata      32-bit read data, one cycle after avs_read
//   avs_readdatavalid one-cycle pulse qualifying avs_readdata
interface multi_pio_bank_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/multi_pio_bank_channel.sv
// pio_channel: one WIDTH-bit PIO channel.
//   clk, rst          clock, async active-high reset
//   pin_in            asynchronous pin inputs
//   armed             enables edge capture once the synchroniser has settled
//   wr_out/wr_mask    write strobes for the output and mask registers
//   wr_cap_clr        write-1-to-clear strobe for the capture register
//   wdata             write data (already truncated to WIDTH)
//   data_in           synchronised pin value
//   data_out          output register (drives the pins)
//   irq_mask          per-bit interrupt enable
//   edge_cap          sticky per-bit edge capture
//   irq_term          OR of (edge_cap & irq_mask), unregistered
module pio_channel
    import multi_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_MODE   = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_OUT   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic             armed,
    input  logic             wr_out,
    input  logic             wr_mask,
    input  logic             wr_cap_clr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] irq_mask,
    output logic [WIDTH-1:0] edge_cap,
    output logic             irq_term
);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] raw_edge_s;
    logic [WIDTH-1:0] event_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] cap_next_s;

    // Metastability synchroniser chain for the pin inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Edge selection; suppressed until the top-level arm counter expires.
    always_comb begin
        raw_edge_s = {WIDTH{1'b0}};
        case (EDGE_MODE)
            EDGE_RISE: raw_edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;
            EDGE_FALL: raw_edge_s = ~sync_r[SYNC_STAGES-1] & prev_r;
            default:   raw_edge_s = sync_r[SYNC_STAGES-1] ^ prev_r;
        endcase
        if (armed) begin
            event_s = raw_edge_s;
        end else begin
            event_s = {WIDTH{1'b0}};
        end
        if (wr_cap_clr) begin
            clr_s = wdata;
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
        // A capture in the same cycle as a clear of that bit keeps the bit set.
        cap_next_s = (cap_r & ~clr_s) | event_s;
    end

    // Delayed copy for edge detection, plus the software-visible registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= {WIDTH{1'b0}};
            out_r  <= RESET_OUT;
            mask_r <= {WIDTH{1'b0}};
            cap_r  <= {WIDTH{1'b0}};
        end else begin
            prev_r <= sync_r[SYNC_STAGES-1];
            cap_r  <= cap_next_s;
            if (wr_out) begin
                out_r <= wdata;
            end
            if (wr_mask) begin
                mask_r <= wdata;
            end
        end
    end

    assign data_in  = sync_r[SYNC_STAGES-1];
    assign data_out = out_r;
    assign irq_mask = mask_r;
    assign edge_cap = cap_r;
    assign irq_term = |(cap_r & mask_r);

endmodule

// File: rtl/multi_pio_bank.sv
// multi_pio_bank: NUM_CH x WIDTH-bit parallel I/O bank on one Avalon-MM slave.
//   clk_clk      system clock
//   reset_reset  asynchronous active-high reset
//   avs          Avalon-MM slave (multi_pio_bank_if.slave), read latency 1
//   irq          registered level interrupt, OR of all masked captures
//   pio_in       pin inputs, channel c at [c*WIDTH +: WIDTH]
//   pio_out      registered pin outputs, same packing
module multi_pio_bank
    import multi_pio_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_MODE   = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_OUT   = {WIDTH{1'b0}}
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    multi_pio_bank_if.slave         avs,
    output logic                    irq,
    input  logic [NUM_CH*WIDTH-1:0] pio_in,
    output logic [NUM_CH*WIDTH-1:0] pio_out
);

    localparam int            ADDR_W   = addr_width(NUM_CH);
    localparam int            ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("multi_pio_bank: NUM_CH must be 1..16");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("multi_pio_bank: WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("multi_pio_bank: SYNC_STAGES must be 2..4");
    end
    if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_ANY) begin : g_bad_edge
        $error("multi_pio_bank: EDGE_MODE must be 0..2");
    end

    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] ch_idx_s;
    reg_sel_e          reg_sel_s;
    logic [WIDTH-1:0]  wdata_s;
    logic              unused_wdata_s;

    logic [WIDTH-1:0]  ch_data_in_s  [NUM_CH];
    logic [WIDTH-1:0]  ch_data_out_s [NUM_CH];
    logic [WIDTH-1:0]  ch_mask_s     [NUM_CH];
    logic [WIDTH-1:0]  ch_cap_s      [NUM_CH];
    logic [NUM_CH-1:0] ch_irq_s;
    logic [NUM_CH-1:0] wr_out_s;
    logic [NUM_CH-1:0] wr_mask_s;
    logic [NUM_CH-1:0] wr_clr_s;

    logic [31:0]       rd_word_s;
    logic [31:0]       readdata_r;
    logic              readdatavalid_r;
    logic [ARM_W-1:0]  arm_cnt_r;
    logic              armed_s;
    logic              irq_r;

    assign addr_s    = avs.avs_address;
    // Channel index above the register offset; out-of-range indices match no channel.
    assign ch_idx_s  = addr_s >> 2;
    assign reg_sel_s = reg_sel_e'(addr_s[1:0]);
    assign wdata_s   = avs.avs_writedata[WIDTH-1:0];
    assign unused_wdata_s = ^avs.avs_writedata;
    assign armed_s   = (arm_cnt_r == ARM_DONE);

    function automatic logic [WIDTH-1:0] reg_field(
        input reg_sel_e         sel,
        input logic [WIDTH-1:0] din,
        input logic [WIDTH-1:0] dout,
        input logic [WIDTH-1:0] mask,
        input logic [WIDTH-1:0] cap
    );
        case (sel)
            REG_DATA_IN:  return din;
            REG_DATA_OUT: return dout;
            REG_IRQ_MASK: return mask;
            REG_EDGE_CAP: return cap;
            default:      return {WIDTH{1'b0}};
        endcase
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit_s;
        assign hit_s        = avs.avs_write && (ch_idx_s == ADDR_W'(c));
        assign wr_out_s[c]  = hit_s && (reg_sel_s == REG_DATA_OUT);
        assign wr_mask_s[c] = hit_s && (reg_sel_s == REG_IRQ_MASK);
        assign wr_clr_s[c]  = hit_s && (reg_sel_s == REG_EDGE_CAP);

        pio_channel #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE),
            .RESET_OUT   (RESET_OUT)
        ) u_ch (
            .clk        (clk_clk),
            .rst        (reset_reset),
            .pin_in     (pio_in[c*WIDTH +: WIDTH]),
            .armed      (armed_s),
            .wr_out     (wr_out_s[c]),
            .wr_mask    (wr_mask_s[c]),
            .wr_cap_clr (wr_clr_s[c]),
            .wdata      (wdata_s),
            .data_in    (ch_data_in_s[c]),
            .data_out   (ch_data_out_s[c]),
            .irq_mask   (ch_mask_s[c]),
            .edge_cap   (ch_cap_s[c]),
            .irq_term   (ch_irq_s[c])
        );

        assign pio_out[c*WIDTH +: WIDTH] = ch_data_out_s[c];
    end

    // Read mux: at most one channel matches, so OR-ing the selected field is exact.
    always_comb begin
        rd_word_s = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            rd_word_s = rd_word_s | ((ch_idx_s == ADDR_W'(c)) ?
                32'(reg_field(reg_sel_s, ch_data_in_s[c], ch_data_out_s[c],
                              ch_mask_s[c], ch_cap_s[c])) : 32'd0);
        end
    end

    // Read response register: data sampled before any same-cycle write lands.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            readdata_r      <= 32'd0;
            readdatavalid_r <= 1'b0;
        end else begin
            readdatavalid_r <= avs.avs_read;
            if (avs.avs_read) begin
                readdata_r <= rd_word_s;
            end
        end
    end

    // Arm counter: holds off edge capture while the synchronisers fill after reset.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            arm_cnt_r <= {ARM_W{1'b0}};
        end else if (!armed_s) begin
            arm_cnt_r <= arm_cnt_r + ARM_W'(1);
        end
    end

    // Registered interrupt, OR of every channel's masked capture.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |ch_irq_s;
        end
    end

    assign avs.avs_readdata      = readdata_r;
    assign avs.avs_readdatavalid = readdatavalid_r;
    assign irq                   = irq_r;

endmodule

// File: doc/multi_pio_bank.md
Name: multi_pio_bank

Overview:
- Parametrised multi-channel parallel I/O peripheral, the successor to the single-purpose red/green/blue/switch PIOs on the Nios system bus.
- Provides NUM_CH independent channels of WIDTH bits, each with:
  - synchronised input;
  - registered output;
  - per-bit edge capture;
  - interrupt mask.
- All channels share one Avalon-MM slave and one interrupt line.
- Sits between the Nios interconnect and board pins (LEDs, switches, colour buses).

Parameters:
NUM_CH, 4, number of channels (1..16)
WIDTH, 8, bits per channel (1..32; elaboration error outside range)
SYNC_STAGES, 2, input synchroniser depth (2..4)
EDGE_MODE, 0, capture edge: 0 rising, 1 falling, 2 any
RESET_OUT, 0, reset value of every channel's output register (WIDTH bits, same for all channels)

Ports:
clk_clk  input  1  system clock, sole clock domain
reset_reset  input  1  asynchronous active-high reset
avs_address  input  clog2(NUM_CH)+2  {channel, register} word address
avs_read  input  1  read strobe
avs_write  input  1  write strobe
avs_writedata  input  32  write data
avs_readdata  output  32  read data, zero-extended above WIDTH
avs_readdatavalid  output  1  one-cycle pulse with read data
irq  output  1  level interrupt to Nios
pio_in  input  NUM_CH*WIDTH  asynchronous pin inputs, channel c at [c*WIDTH +: WIDTH]
pio_out  output  NUM_CH*WIDTH  registered pin outputs, same packing

Behaviour:
- Reset (async assert, sync release):
  - pio_out = RESET_OUT per channel;
  - synchronisers, edge_cap, irq_mask = 0;
  - avs_readdata = 0, avs_readdatavalid = 0, irq = 0;
  - arm counter = 0.
- Register map per channel, word offset = avs_address[1:0]:
  - 0 DATA_IN: read-only, synchronised input; writes ignored.
  - 1 DATA_OUT: read/write; drives pio_out.
  - 2 IRQ_MASK: read/write; 1 enables that bit's interrupt.
  - 3 EDGE_CAP: read; write-1-to-clear per bit.
- Channel select = avs_address[MSBs]. Channel index >= NUM_CH: reads return 0 (valid still pulses), writes ignored.
- Writes take effect on the clock edge where avs_write=1; pio_out changes that same edge. writedata bits above WIDTH are ignored.
- Read latency is fixed at 1:
  - avs_readdatavalid is high exactly the cycle after avs_read=1;
  - avs_readdata is held until the next read.
- Read and write to the same register in the same cycle: the read returns the pre-write value.
- Input path: SYNC_STAGES flops per bit. A pin change is visible in DATA_IN SYNC_STAGES cycles later.
- Edge detect: compares the synchroniser output against a one-cycle-delayed copy. edge_cap bit is set the cycle after the edge appears at the synchroniser output (SYNC_STAGES+1 cycles after the pin change).
- Arm counter:
  - after reset release, counts to SYNC_STAGES+1;
  - edge detection is suppressed until terminal count, so a pin held high through reset never produces a spurious capture;
  - the counter saturates and holds.
- Simultaneous capture event and W1C clear on the same bit: the set wins, bit stays 1.
- Captured bits persist until cleared. Further edges do not toggle a set bit.
- irq is registered: irq = OR over all channels of (edge_cap & irq_mask), one cycle after the contributing term changes.
- Unmasking a bit already captured raises irq one cycle later.
- Reset mid-transaction: a pending readdatavalid is dropped, and all state returns to reset values immediately.

Decomposition:
- Package multi_pio_pkg holds:
  - register offset constants REG_DATA_IN, REG_DATA_OUT, REG_IRQ_MASK, REG_EDGE_CAP;
  - edge-mode encoding constants EDGE_RISE, EDGE_FALL, EDGE_ANY;
  - a function for address width.
- Sub-module pio_channel holds one channel's synchroniser, edge detector, edge_cap, irq_mask and out register.
- The top level instantiates pio_channel NUM_CH times and adds the bus decode, read mux, arm counter and irq OR.

Test Plan:
1. Reset, then read ch0 DATA_OUT with RESET_OUT=8'hA5 -> readdatavalid one cycle after read, readdata=32'h000000A5, pio_out[7:0]=8'hA5.
2. Write 8'h3C to ch2 DATA_OUT (address 4'b1001) -> pio_out[23:16]=8'h3C on the same edge; other channels unchanged; read-back returns 32'h3C.
3. EDGE_MODE=0, ch1 mask=8'h01, pulse pio_in[8] 0->1 -> DATA_IN bit0=1 after 2 cycles, EDGE_CAP=8'h01 after 3 cycles, irq=1 after 4 cycles.
4. Write 8'h01 to ch1 EDGE_CAP on the same cycle a new rising edge is captured on bit0 -> EDGE_CAP stays 8'h01 and irq stays 1. Clear with no edge -> irq=0 one cycle later.
5. Hold pio_in=all ones through reset release -> EDGE_CAP=0 on every channel and irq=0 for 20 cycles.
6. NUM_CH=3, read address 4'b1100 (channel 3) -> readdata=0 with valid pulse; write to it -> no output change. Assert reset between read and valid -> readdatavalid stays 0.
